fft_iter_r2: RTL

FFT_ITER_R2 -- requirements
Module: fft_iter_r2

---
 rtl/fft_pkg.sv | 48 ++++
 rtl/fft_bfly_r2.sv | 52 +++++
 rtl/fft_iter_r2.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the iterative radix-2 FFT.
//   state_t    : control FSM states (LOAD, COMPUTE, UNLOAD)
//   clog2      : integer ceil(log2(v)) usable in constant expressions
//   bitrev     : reverse the low 'bits' bits of v
//   tw_re/tw_im: twiddle ROM generation, W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N),
//                quantised to signed Q1.(TW-1), round to nearest, +1.0 clamped
//                to 2^(TW-1)-1. Valid for TW <= 31.
package fft_pkg;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits && v[i]) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    function automatic int tw_quant(input real v, input int tw);
        real scaled = v * (2.0 ** (tw - 1));
        int  q      = int'($floor(scaled + 0.5));
        int  maxv   = (1 << (tw - 1)) - 1;
        if (q > maxv) q = maxv;
        return q;
    endfunction

    function automatic int tw_re(input int n, input int tw, input int k);
        return tw_quant($cos(2.0 * PI * k / n), tw);
    endfunction

    function automatic int tw_im(input int n, input int tw, input int k);
        return tw_quant(-$sin(2.0 * PI * k / n), tw);
    endfunction

endpackage

// File: rtl/fft_bfly_r2.sv
// Combinational radix-2 DIT butterfly with per-stage scaling by 1/2.
//   a, b   : input pair (signed DW-bit real/imag)
//   w      : twiddle, signed Q1.(TW-1)
//   w_one  : twiddle is exactly 1 (k = 0); product is bypassed
//   x, y   : x = (a + b*w) >>> 1, y = (a - b*w) >>> 1
// The product uses full-width intermediates and an arithmetic shift by
// TW-1, i.e. truncation toward minus infinity.
module fft_bfly_r2 #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    input  logic                 w_one,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
);
    localparam int PW = DW + TW + 1;

    logic signed [PW-1:0] m_re, m_im, p_re, p_im;
    logic signed [PW-1:0] s_re, s_im, d_re, d_im;
    logic                 unused_bits;

    assign m_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    assign m_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);

    // W^0 is exactly 1, but the ROM can only hold 1 - 2^-(TW-1); multiplying
    // by that would pull every k=0 butterfly down one LSB per stage.
    assign p_re = w_one ? PW'(b_re) : (m_re >>> (TW - 1));
    assign p_im = w_one ? PW'(b_im) : (m_im >>> (TW - 1));

    assign s_re = PW'(a_re) + p_re;
    assign s_im = PW'(a_im) + p_im;
    assign d_re = PW'(a_re) - p_re;
    assign d_im = PW'(a_im) - p_im;

    // Dropping bit 0 is the >>>1; the upper bits are sign copies.
    assign x_re = s_re[DW:1];
    assign x_im = s_im[DW:1];
    assign y_re = d_re[DW:1];
    assign y_im = d_im[DW:1];

    assign unused_bits = ^{s_re[PW-1:DW+1], s_re[0], s_im[PW-1:DW+1], s_im[0],
                           d_re[PW-1:DW+1], d_re[0], d_im[PW-1:DW+1], d_im[0]};

endmodule

// File: rtl/fft_iter_r2.sv
// Iterative in-place radix-2 DIT FFT, one butterfly per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, samples x[0..N-1] in natural order
//   in_re, in_im        : input sample
//   out_valid/out_ready : output handshake, bins X[0..N-1] in natural order
//   out_re, out_im      : output bin (DFT/N)
//   out_idx             : bin index of the current output
//   busy                : high while butterflies are being computed
// Frame flow: LOAD (N beats, bit-reversed writes) -> COMPUTE ((N/2)*log2(N)
// cycles) -> UNLOAD (N beats) -> LOAD.
module fft_iter_r2
    import fft_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [DW-1:0]  in_re,
    input  logic signed [DW-1:0]  in_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [DW-1:0]  out_re,
    output logic signed [DW-1:0]  out_im,
    output logic [$clog2(N)-1:0]  out_idx,
    output logic                  busy
);
    localparam int LOGN = clog2(N);
    localparam int HALF = N / 2;
    localparam int BW   = LOGN - 1;

    state_t          state, state_nxt;
    logic [LOGN-1:0] cnt;       // load / unload index
    logic [BW-1:0]   bf;        // butterfly index within a stage
    logic [2:0]      stage;
    logic            rdy_en;    // holds in_ready low until the first edge after reset

    logic signed [DW-1:0] mem_re [N];
    logic signed [DW-1:0] mem_im [N];
    logic signed [TW-1:0] rom_re [HALF];
    logic signed [TW-1:0] rom_im [HALF];

    logic            in_fire, out_fire, last_bf, last_stage;
    logic [LOGN-1:0] load_addr, ia, ib;
    logic [BW-1:0]   tw_k;
    logic signed [DW-1:0] x_re, x_im, y_re, y_im;
    int              s_i, pos_i, base_i;

    for (genvar k = 0; k < HALF; k++) begin : g_rom
        localparam int WR = tw_re(N, TW, k);
        localparam int WI = tw_im(N, TW, k);
        assign rom_re[k] = TW'(WR);
        assign rom_im[k] = TW'(WI);
    end

    assign in_ready   = rdy_en && (state == S_LOAD);
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = (state == S_UNLOAD);
    assign out_fire   = out_valid && out_ready;
    assign busy       = (state == S_COMPUTE);
    assign last_bf    = (bf == BW'(HALF - 1));
    assign last_stage = (stage == 3'(LOGN - 1));
    assign load_addr  = LOGN'(bitrev(int'(cnt), LOGN));

    // Stage s, butterfly j: pairs are 2^s apart inside groups of 2^(s+1);
    // twiddle exponent is (j mod 2^s) * N / 2^(s+1).
    always_comb begin
        s_i    = int'(stage);
        pos_i  = int'(bf) & ((1 << s_i) - 1);
        base_i = ((int'(bf) >> s_i) << (s_i + 1)) | pos_i;
        ia     = LOGN'(base_i);
        ib     = LOGN'(base_i | (1 << s_i));
        tw_k   = BW'(pos_i << (BW - s_i));
    end

    fft_bfly_r2 #(.DW(DW), .TW(TW)) u_bfly (
        .a_re  (mem_re[ia]),
        .a_im  (mem_im[ia]),
        .b_re  (mem_re[ib]),
        .b_im  (mem_im[ib]),
        .w_re  (rom_re[tw_k]),
        .w_im  (rom_im[tw_k]),
        .w_one (tw_k == '0),
        .x_re  (x_re),
        .x_im  (x_im),
        .y_re  (y_re),
        .y_im  (y_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if (in_fire && cnt == LOGN'(N - 1))   state_nxt = S_COMPUTE;
            S_COMPUTE: if (last_bf && last_stage)            state_nxt = S_UNLOAD;
            S_UNLOAD:  if (out_fire && cnt == LOGN'(N - 1))  state_nxt = S_LOAD;
            default:                                         state_nxt = S_LOAD;
        endcase
    end

    // cnt wraps at N by width; bf wraps at N/2 by width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            bf     <= '0;
            stage  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_LOAD:   if (in_fire)  cnt <= cnt + LOGN'(1);
                S_UNLOAD: if (out_fire) cnt <= cnt + LOGN'(1);
                S_COMPUTE: begin
                    bf <= bf + BW'(1);
                    if (last_bf) stage <= last_stage ? 3'd0 : stage + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Register file: deliberately not reset; only UNLOAD exposes it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re[load_addr] <= in_re;
            mem_im[load_addr] <= in_im;
        end else if (state == S_COMPUTE) begin
            mem_re[ia] <= x_re;
            mem_im[ia] <= x_im;
            mem_re[ib] <= y_re;
            mem_im[ib] <= y_im;
        end
    end

    assign out_re  = out_valid ? mem_re[cnt] : '0;
    assign out_im  = out_valid ? mem_im[cnt] : '0;
    assign out_idx = out_valid ? cnt : '0;

endmodule
